// File: rtl/piece_sequencer_pkg.sv
// Shared piece-type codes, sequencer state encoding and bag helpers for piece_sequencer.
package piece_sequencer_pkg;

  localparam int TYPE_CODE_W = 3;

  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE1     = 3'd1;
  localparam logic [2:0] TYPE2     = 3'd2;
  localparam logic [2:0] TYPE3     = 3'd3;
  localparam logic [2:0] TYPE4     = 3'd4;
  localparam logic [2:0] TYPE5     = 3'd5;
  localparam logic [2:0] TYPE6     = 3'd6;
  localparam logic [2:0] TYPE7     = 3'd7;

  localparam logic [6:0] BAG_FULL = 7'h7f;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CHECK = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_SPAWN = 3'd3,
    SEQ_PLAY  = 3'd4,
    SEQ_CLEAR = 3'd5,
    SEQ_OVER  = 3'd6
  } seq_state_e;

  // Code 0 from the generator is folded onto TYPE1.
  function automatic logic [2:0] norm_type(input logic [2:0] t);
    return (t == TYPE_NONE) ? TYPE1 : t;
  endfunction

  function automatic logic [6:0] type_bit(input logic [2:0] t);
    return 7'b1 << (norm_type(t) - 3'd1);
  endfunction

endpackage

// File: rtl/piece_sequencer_bag_tracker.sv
// 7-bag history: combinational repeat hit, marking with rollover to empty once all seven are seen.
import piece_sequencer_pkg::*;

module bag_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       mark,
  input  logic [2:0] type_in,
  output logic       hit
);

  logic [6:0] bag;
  logic [6:0] bag_next;

  assign hit      = |(bag & type_bit(type_in));
  assign bag_next = bag | type_bit(type_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bag <= 7'b0;
    end else if (clr) begin
      bag <= 7'b0;
    end else if (mark) begin
      bag <= (bag_next == BAG_FULL) ? 7'b0 : bag_next;
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// Game-flow controller: draws from the next-piece generator with bag repeat filtering, spawn/play/clear/over.
// Optional hold slot enabled by defining PIECE_HOLD_EN.
import piece_sequencer_pkg::*;

module piece_sequencer #(
  parameter int MAX_REROLL = 3,
  parameter int TYPE_W     = TYPE_CODE_W
) (
  input  logic              CLK_25M,
  input  logic              key_reset_n,
  input  logic              key_start,
  input  logic [TYPE_W-1:0] next_type,
  input  logic              piece_landed,
  input  logic              clear_done,
  input  logic              spawn_blocked,
`ifdef PIECE_HOLD_EN
  input  logic              hold_req,
  output logic [TYPE_W-1:0] hold_type,
`endif
  output logic              Update,
  output logic [TYPE_W-1:0] cur_type,
  output logic              spawn,
  output logic              clear_req,
  output logic              game_over,
  output logic              playing
);

  localparam int RC_W = $clog2(MAX_REROLL + 1);

  seq_state_e      state;
  logic [RC_W-1:0] reroll_cnt;
  logic            first_play;
  logic            bag_hit;
  logic            reroll;
  logic            bag_clr;
  logic            bag_mark;
`ifdef PIECE_HOLD_EN
  logic            hold_used;
`endif

  assign reroll   = bag_hit && (reroll_cnt < RC_W'(MAX_REROLL));
  assign bag_clr  = ((state == SEQ_IDLE) || (state == SEQ_OVER)) && key_start;
  assign bag_mark = (state == SEQ_CHECK) && !reroll;

  bag_tracker u_bag (
    .clk     (CLK_25M),
    .rst_n   (key_reset_n),
    .clr     (bag_clr),
    .mark    (bag_mark),
    .type_in (next_type),
    .hit     (bag_hit)
  );

  always_ff @(posedge CLK_25M or negedge key_reset_n) begin
    if (!key_reset_n) begin
      state      <= SEQ_IDLE;
      reroll_cnt <= '0;
      first_play <= 1'b0;
      cur_type   <= '0;
      Update     <= 1'b0;
      spawn      <= 1'b0;
      clear_req  <= 1'b0;
      game_over  <= 1'b0;
      playing    <= 1'b0;
`ifdef PIECE_HOLD_EN
      hold_type  <= '0;
      hold_used  <= 1'b0;
`endif
    end else begin
      Update <= 1'b0;
      spawn  <= 1'b0;
      case (state)
        SEQ_IDLE, SEQ_OVER: begin
          if (key_start) begin
            reroll_cnt <= '0;
            game_over  <= 1'b0;
            state      <= SEQ_CHECK;
`ifdef PIECE_HOLD_EN
            hold_type  <= '0;
            hold_used  <= 1'b0;
`endif
          end
        end
        SEQ_CHECK: begin
          Update <= 1'b1;
          if (reroll) begin
            reroll_cnt <= reroll_cnt + 1'b1;
            state      <= SEQ_WAIT;
          end else begin
            cur_type   <= norm_type(next_type);
            reroll_cnt <= '0;
            state      <= SEQ_SPAWN;
`ifdef PIECE_HOLD_EN
            hold_used  <= 1'b0;
`endif
          end
        end
        SEQ_WAIT: state <= SEQ_CHECK;
        SEQ_SPAWN: begin
          spawn      <= 1'b1;
          first_play <= 1'b1;
          playing    <= 1'b1;
          state      <= SEQ_PLAY;
        end
        SEQ_PLAY: begin
          // The spawn pulse is still out while first_play && spawn; the board answers one cycle later.
          if (first_play && !spawn) first_play <= 1'b0;
          if (first_play && !spawn && spawn_blocked) begin
            playing   <= 1'b0;
            game_over <= 1'b1;
            state     <= SEQ_OVER;
          end else if (piece_landed) begin
            playing   <= 1'b0;
            clear_req <= 1'b1;
            state     <= SEQ_CLEAR;
          end
`ifdef PIECE_HOLD_EN
          else if (hold_req && !hold_used) begin
            hold_used <= 1'b1;
            playing   <= 1'b0;
            hold_type <= cur_type;
            if (hold_type == TYPE_NONE) begin
              state <= SEQ_CHECK;
            end else begin
              cur_type <= hold_type;
              state    <= SEQ_SPAWN;
            end
          end
`endif
        end
        SEQ_CLEAR: begin
          if (clear_done) begin
            clear_req <= 1'b0;
            state     <= SEQ_CHECK;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer with a simple next-piece generator model.
import piece_sequencer_pkg::*;

module tb_piece_sequencer;

  logic       CLK_25M = 1'b0;
  logic       key_reset_n = 1'b0;
  logic       key_start = 1'b0;
  logic [2:0] next_type;
  logic       piece_landed = 1'b0;
  logic       clear_done = 1'b0;
  logic       spawn_blocked = 1'b0;
  logic       Update;
  logic [2:0] cur_type;
  logic       spawn;
  logic       clear_req;
  logic       game_over;
  logic       playing;
`ifdef PIECE_HOLD_EN
  logic       hold_req = 1'b0;
  logic [2:0] hold_type;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] gen_seq [0:31];
  int         gen_idx = 0;
  int         upd_cnt = 0;

  piece_sequencer #(.MAX_REROLL(3), .TYPE_W(3)) dut (
    .CLK_25M       (CLK_25M),
    .key_reset_n   (key_reset_n),
    .key_start     (key_start),
    .next_type     (next_type),
    .piece_landed  (piece_landed),
    .clear_done    (clear_done),
    .spawn_blocked (spawn_blocked),
`ifdef PIECE_HOLD_EN
    .hold_req      (hold_req),
    .hold_type     (hold_type),
`endif
    .Update        (Update),
    .cur_type      (cur_type),
    .spawn         (spawn),
    .clear_req     (clear_req),
    .game_over     (game_over),
    .playing       (playing)
  );

  always #20 CLK_25M = ~CLK_25M;

  // Generator model: preview advances on each Update, new value visible the following cycle.
  assign next_type = gen_seq[gen_idx];
  always @(posedge CLK_25M) begin
    if (Update === 1'b1) begin
      gen_idx <= gen_idx + 1;
      upd_cnt <= upd_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_25M);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_draw(input string tag, input int exp_lat, input logic [2:0] exp_type,
                         input int exp_upd);
    int u0;
    int lat;
    u0  = upd_cnt;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (spawn === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_type"}, {29'b0, cur_type}, {29'b0, exp_type});
    chk({tag, "_upd"}, upd_cnt - u0, exp_upd);
  endtask

  task automatic land_and_clear(input string tag);
    step(2);
    piece_landed = 1'b1;
    step(1);
    piece_landed = 1'b0;
    chk({tag, "_req_rise"}, {31'b0, clear_req}, 1);
    chk({tag, "_not_playing"}, {31'b0, playing}, 0);
    step(9);
    chk({tag, "_req_held"}, {31'b0, clear_req}, 1);
    clear_done = 1'b1;
    step(1);
    clear_done = 1'b0;
    chk({tag, "_req_drop"}, {31'b0, clear_req}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] mids [0:4];
    mids = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    gen_seq = '{default: 3'd3};
    gen_seq[0]  = 3'd5;
    gen_seq[1]  = 3'd5;
    gen_seq[2]  = 3'd5;
    gen_seq[3]  = 3'd5;
    gen_seq[4]  = 3'd5;
    gen_seq[5]  = 3'd1;
    gen_seq[6]  = 3'd2;
    gen_seq[7]  = 3'd3;
    gen_seq[8]  = 3'd4;
    gen_seq[9]  = 3'd6;
    gen_seq[10] = 3'd7;
    gen_seq[11] = 3'd5;
    gen_seq[12] = 3'd0;
    gen_seq[13] = 3'd5;

    // Reset state
    step(2);
    chk("rst_update", {31'b0, Update}, 0);
    chk("rst_cur_type", {29'b0, cur_type}, 0);
    chk("rst_spawn", {31'b0, spawn}, 0);
    chk("rst_clear_req", {31'b0, clear_req}, 0);
    chk("rst_game_over", {31'b0, game_over}, 0);
    chk("rst_playing", {31'b0, playing}, 0);
    chk("rst_bag", {25'b0, dut.u_bag.bag}, 0);
    key_reset_n = 1'b1;
    step(2);
    chk("idle_no_spawn", {31'b0, spawn}, 0);

    // First draw: start to spawn in 3 cycles, one Update, bag holds only type 5
    key_start = 1'b1;
    do_draw("d1", 3, 3'd5, 1);
    key_start = 1'b0;
    chk("d1_bag", {25'b0, dut.u_bag.bag}, 32'h10);
    chk("d1_playing", {31'b0, playing}, 1);

    // Type 5 previewed four times: three rerolls then forced acceptance
    land_and_clear("c1");
    do_draw("d2_reroll", 8, 3'd5, 4);
    chk("d2_bag", {25'b0, dut.u_bag.bag}, 32'h10);

    // key_start is ignored during PLAY
    key_start = 1'b1;
    step(1);
    key_start = 1'b0;
    chk("play_ignore_start", {31'b0, playing}, 1);
    chk("play_ignore_start_spawn", {31'b0, spawn}, 0);

    for (int i = 0; i < 5; i++) begin
      land_and_clear($sformatf("cm%0d", i));
      do_draw($sformatf("dm%0d", i), 2, mids[i], 1);
    end
    chk("pre_full_bag", {25'b0, dut.u_bag.bag}, 32'h3f);

    // Seventh distinct type fills the bag, which rolls over to empty
    land_and_clear("c7");
    do_draw("d7", 2, 3'd7, 1);
    chk("rollover_bag", {25'b0, dut.u_bag.bag}, 0);

    land_and_clear("c8");
    do_draw("d8", 2, 3'd5, 1);
    chk("d8_bag", {25'b0, dut.u_bag.bag}, 32'h10);

    // Preview code 0 is taken as TYPE1
    land_and_clear("c9");
    do_draw("d9_zero", 2, 3'd1, 1);
    chk("d9_bag", {25'b0, dut.u_bag.bag}, 32'h11);

    // Blocked spawn beats a same-cycle landing
    step(1);
    spawn_blocked = 1'b1;
    piece_landed  = 1'b1;
    step(1);
    spawn_blocked = 1'b0;
    piece_landed  = 1'b0;
    chk("over_game_over", {31'b0, game_over}, 1);
    chk("over_playing", {31'b0, playing}, 0);
    chk("over_no_clear", {31'b0, clear_req}, 0);
    piece_landed = 1'b1;
    step(1);
    piece_landed = 1'b0;
    chk("over_ignore_land", {31'b0, clear_req}, 0);
    chk("over_hold", {31'b0, game_over}, 1);

    // Restart from OVER with an empty bag: type 5 is accepted without reroll
    key_start = 1'b1;
    do_draw("restart", 3, 3'd5, 1);
    key_start = 1'b0;
    chk("restart_game_over", {31'b0, game_over}, 0);
    chk("restart_bag", {25'b0, dut.u_bag.bag}, 32'h10);

    // Asynchronous reset while clearing
    step(2);
    piece_landed = 1'b1;
    step(1);
    piece_landed = 1'b0;
    chk("rst2_in_clear", {31'b0, clear_req}, 1);
    step(2);
    #5 key_reset_n = 1'b0;
    #1;
    chk("rst2_clear_req", {31'b0, clear_req}, 0);
    chk("rst2_cur_type", {29'b0, cur_type}, 0);
    chk("rst2_playing", {31'b0, playing}, 0);
    chk("rst2_update", {31'b0, Update}, 0);
    chk("rst2_bag", {25'b0, dut.u_bag.bag}, 0);
    step(1);
    key_reset_n = 1'b1;
    step(1);
    chk("rst2_state_idle", {29'b0, dut.state}, {29'b0, SEQ_IDLE});
    step(3);
    chk("rst2_idle_spawn", {31'b0, spawn}, 0);
    chk("rst2_idle_game_over", {31'b0, game_over}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
